// File: rtl/fall_sequencer_pkg.sv
// Shared definitions between the fall sequencer and the row units:
// broadcast state codes, internal FSM states and the default board height.
package tetris_pkg;

   localparam int ROWS_DEF = 20;

   localparam logic [2:0] ST_CHECK = 3'b000;
   localparam logic [2:0] ST_MOVE  = 3'b001;
   localparam logic [2:0] ST_WRITE = 3'b010;
   localparam logic [2:0] ST_SHIFT = 3'b011;
   localparam logic [2:0] ST_ADD   = 3'b100;

   typedef enum logic [2:0] {
      S_CHECK,
      S_SHIFT,
      S_ADD,
      S_SPAWN_CHK,
      S_FALL_WAIT,
      S_FALL,
      S_WRITE,
      S_HALT
   } fsm_e;

endpackage

// File: rtl/fall_sequencer_if.sv
// Board-facing bus of the fall sequencer. The drop input exists only when
// FALL_SEQ_SOFT_DROP_EN is defined.
interface fall_sequencer_if
   import tetris_pkg::*;
   #(parameter int ROWS = ROWS_DEF,
     parameter int LINES_W = 16);

   localparam int SR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [ROWS-1:0]    row_full;
   logic               stop_any;
   logic               endgame_any;
`ifdef FALL_SEQ_SOFT_DROP_EN
   logic               drop;
`endif
   logic [2:0]         state;
   logic               shift_en;
   logic [SR_W-1:0]    shift_row;
   logic               spawn;
   logic               game_over;
   logic [LINES_W-1:0] lines;

`ifdef FALL_SEQ_SOFT_DROP_EN
   modport master (input row_full, stop_any, endgame_any, drop,
                   output state, shift_en, shift_row, spawn, game_over, lines);
   modport slave  (output row_full, stop_any, endgame_any, drop,
                   input state, shift_en, shift_row, spawn, game_over, lines);
`else
   modport master (input row_full, stop_any, endgame_any,
                   output state, shift_en, shift_row, spawn, game_over, lines);
   modport slave  (output row_full, stop_any, endgame_any,
                   input state, shift_en, shift_row, spawn, game_over, lines);
`endif

endinterface

// File: rtl/fall_sequencer_gravity_timer.sv
// Gravity tick generator: counts while enabled, ticks at GRAVITY_DIV-1.
// With FALL_SEQ_SOFT_DROP_EN, drop=1 lowers the threshold to GRAVITY_DIV/8-1 (min 1).
module gravity_timer #(
   parameter int GRAVITY_DIV = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
`ifdef FALL_SEQ_SOFT_DROP_EN
   input  logic i_drop,
`endif
   output logic o_tick
);

   localparam int CW = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;
   localparam logic [CW-1:0] TOP = CW'(GRAVITY_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_hit;

`ifdef FALL_SEQ_SOFT_DROP_EN
   localparam int DROP_RAW = GRAVITY_DIV / 8 - 1;
   localparam logic [CW-1:0] DROP_TH = CW'((DROP_RAW < 1) ? 1 : DROP_RAW);
   assign w_hit = i_drop ? (r_cnt >= DROP_TH) : (r_cnt == TOP);
`else
   assign w_hit = (r_cnt == TOP);
`endif

   assign o_tick = i_en && w_hit;

   always_ff @(posedge clk) begin
      if (reset || i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
   end

endmodule

// File: rtl/fall_sequencer.sv
// Game-level sequencer: drives the row-unit state code, picks the row to clear,
// runs gravity, counts lines and latches game over. Optional FALL_SEQ_SOFT_DROP_EN.
module fall_sequencer
   import tetris_pkg::*;
   #(parameter int ROWS = ROWS_DEF,
     parameter int GRAVITY_DIV = 25000000,
     parameter int LINES_W = 16)
   (
   input  logic             clk,
   input  logic             reset,
   fall_sequencer_if.master bus
);

   localparam int SR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   fsm_e               r_st, w_nxt;
   logic [SR_W-1:0]    r_shift_row;
   logic [LINES_W-1:0] r_lines;
   logic               w_tmr_en, w_tmr_clr, w_tick;
   logic [2:0]         w_code;

   // Bottom-most full row wins: later (higher) indices overwrite earlier ones.
   function automatic logic [SR_W-1:0] hi_idx(input logic [ROWS-1:0] v);
      hi_idx = '0;
      for (int r = 0; r < ROWS; r++)
         if (v[r]) hi_idx = SR_W'(r);
   endfunction

   gravity_timer #(.GRAVITY_DIV(GRAVITY_DIV)) u_tmr (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_tmr_en),
      .i_clr  (w_tmr_clr),
`ifdef FALL_SEQ_SOFT_DROP_EN
      .i_drop (bus.drop),
`endif
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) r_st <= S_CHECK;
      else       r_st <= w_nxt;
   end

   always_comb begin
      w_nxt     = r_st;
      w_tmr_en  = 1'b0;
      w_tmr_clr = 1'b0;
      case (r_st)
         S_CHECK:     w_nxt = (|bus.row_full) ? S_SHIFT : S_ADD;
         S_SHIFT:     w_nxt = S_CHECK;
         S_ADD:       w_nxt = S_SPAWN_CHK;
         S_SPAWN_CHK: begin
            if (bus.endgame_any) begin
               w_nxt = S_HALT;
            end else begin
               w_tmr_clr = 1'b1;
               w_nxt     = S_FALL_WAIT;
            end
         end
         S_FALL_WAIT: begin
            w_tmr_en = 1'b1;
            if (w_tick) w_nxt = bus.stop_any ? S_WRITE : S_FALL;
         end
         S_FALL:      w_nxt = S_FALL_WAIT;
         S_WRITE:     w_nxt = S_CHECK;
         S_HALT:      w_nxt = S_HALT;
         default:     w_nxt = S_CHECK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift_row <= '0;
         r_lines     <= '0;
      end else begin
         if (r_st == S_CHECK && (|bus.row_full))
            r_shift_row <= hi_idx(bus.row_full);
         if (r_st == S_SHIFT && r_lines != '1)
            r_lines <= r_lines + 1'b1;
      end
   end

   always_comb begin
      w_code = ST_CHECK;
      case (r_st)
         S_SHIFT: w_code = ST_SHIFT;
         S_ADD:   w_code = ST_ADD;
         S_FALL:  w_code = ST_MOVE;
         S_WRITE: w_code = ST_WRITE;
         default: w_code = ST_CHECK;
      endcase
   end

   assign bus.state     = w_code;
   assign bus.shift_en  = (r_st == S_SHIFT);
   assign bus.shift_row = r_shift_row;
   assign bus.spawn     = (r_st == S_ADD);
   assign bus.game_over = (r_st == S_HALT);
   assign bus.lines     = r_lines;

endmodule

// File: tb/tb_fall_sequencer.sv
// Directed bench for fall_sequencer (GRAVITY_DIV=4); a second 3-bit-lines
// instance checks counter saturation. Soft drop is covered when the macro is set.
module tb_fall_sequencer;
   import tetris_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fall_sequencer_if #(.ROWS(20), .LINES_W(16)) sbus ();
   fall_sequencer_if #(.ROWS(20), .LINES_W(3))  sbus2 ();

   fall_sequencer #(.ROWS(20), .GRAVITY_DIV(4), .LINES_W(16)) dut (
      .clk(clk), .reset(reset), .bus(sbus));

   fall_sequencer #(.ROWS(20), .GRAVITY_DIV(4), .LINES_W(3)) dut_sat (
      .clk(clk), .reset(reset), .bus(sbus2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fall();
      int n;
      n = 0;
      while (sbus.state !== ST_MOVE && n < 40) begin
         step();
         n++;
      end
      n_tests++;
      if (sbus.state !== ST_MOVE) begin
         n_fail++;
         $display("FAIL wait_fall: state=%b, required 001 within 40 cycles", sbus.state);
      end
   endtask

   // From anywhere in the fall loop: finish the next gravity period with stop_any on the tick.
   task automatic go_write();
      wait_fall();
      repeat (4) step();
      sbus.stop_any = 1'b1;
      step();
      sbus.stop_any = 1'b0;
      n_tests++;
      if (sbus.state !== ST_WRITE) begin
         n_fail++;
         $display("FAIL go_write: state=%b, required 010", sbus.state);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sbus.row_full = '0; sbus.stop_any = 0; sbus.endgame_any = 0;
      sbus2.row_full = '0; sbus2.stop_any = 0; sbus2.endgame_any = 0;
`ifdef FALL_SEQ_SOFT_DROP_EN
      sbus.drop = 0; sbus2.drop = 0;
`endif
      step(); step();
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.game_over !== 1'b0 || sbus.lines !== 16'd0 ||
          sbus.shift_en !== 1'b0 || sbus.spawn !== 1'b0 || sbus.shift_row !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_vals: state=%b go=%b lines=%0d se=%b sp=%b row=%0d, required 000/0/0/0/0/0",
                  sbus.state, sbus.game_over, sbus.lines, sbus.shift_en, sbus.spawn, sbus.shift_row);
      end
      reset = 1'b0;
      step();
      n_tests++;
      if (sbus.state !== 3'b100 || sbus.spawn !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_add: state=%b spawn=%b, required 100/1", sbus.state, sbus.spawn);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.spawn !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_spawnchk: state=%b spawn=%b, required 000/0", sbus.state, sbus.spawn);
      end
   endtask

   task automatic test_fall();
      int n;
      wait_fall();
      n = 0;
      do begin
         step();
         n++;
      end while (sbus.state !== ST_MOVE && n < 12);
      n_tests++;
      if (n !== 5) begin
         n_fail++;
         $display("FAIL fall_period: period=%0d, required 5", n);
      end
      // stop_any outside the tick cycle must be ignored
      sbus.stop_any = 1'b1;
      step(); step(); step();
      sbus.stop_any = 1'b0;
      step();
      n_tests++;
      if (sbus.state !== 3'b000) begin
         n_fail++;
         $display("FAIL fall_wait_hold: state=%b, required 000", sbus.state);
      end
      step();
      n_tests++;
      if (sbus.state !== ST_MOVE) begin
         n_fail++;
         $display("FAIL stop_off_tick: state=%b, required 001", sbus.state);
      end
      go_write();
      step();
      n_tests++;
      if (sbus.state !== 3'b000) begin
         n_fail++;
         $display("FAIL write_check: state=%b, required 000", sbus.state);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b100) begin
         n_fail++;
         $display("FAIL check_add: state=%b, required 100", sbus.state);
      end
   endtask

   task automatic test_double_clear();
      go_write();
      sbus.row_full = 20'h80000;
      step();
      step();
      n_tests++;
      if (sbus.state !== 3'b011 || sbus.shift_en !== 1'b1 || sbus.shift_row !== 5'd19 || sbus.lines !== 16'd0) begin
         n_fail++;
         $display("FAIL dbl_shift1: state=%b se=%b row=%0d lines=%0d, required 011/1/19/0",
                  sbus.state, sbus.shift_en, sbus.shift_row, sbus.lines);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.lines !== 16'd1 || sbus.shift_en !== 1'b0) begin
         n_fail++;
         $display("FAIL dbl_check: state=%b lines=%0d se=%b, required 000/1/0", sbus.state, sbus.lines, sbus.shift_en);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b011 || sbus.shift_row !== 5'd19) begin
         n_fail++;
         $display("FAIL dbl_shift2: state=%b row=%0d, required 011/19", sbus.state, sbus.shift_row);
      end
      sbus.row_full = '0;
      step();
      n_tests++;
      if (sbus.lines !== 16'd2) begin
         n_fail++;
         $display("FAIL dbl_lines: lines=%0d, required 2", sbus.lines);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b100) begin
         n_fail++;
         $display("FAIL dbl_add: state=%b, required 100", sbus.state);
      end
   endtask

   task automatic test_priority();
      go_write();
      sbus.row_full = 20'h00402;
      step(); step();
      n_tests++;
      if (sbus.state !== 3'b011 || sbus.shift_row !== 5'd10) begin
         n_fail++;
         $display("FAIL prio_first: state=%b row=%0d, required 011/10", sbus.state, sbus.shift_row);
      end
      sbus.row_full = 20'h00002;
      step();
      n_tests++;
      if (sbus.lines !== 16'd3) begin
         n_fail++;
         $display("FAIL prio_lines1: lines=%0d, required 3", sbus.lines);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b011 || sbus.shift_row !== 5'd1) begin
         n_fail++;
         $display("FAIL prio_second: state=%b row=%0d, required 011/1", sbus.state, sbus.shift_row);
      end
      sbus.row_full = '0;
      step();
      n_tests++;
      if (sbus.lines !== 16'd4) begin
         n_fail++;
         $display("FAIL prio_lines2: lines=%0d, required 4", sbus.lines);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b100 || sbus.shift_row !== 5'd1) begin
         n_fail++;
         $display("FAIL prio_add: state=%b row=%0d, required 100/1", sbus.state, sbus.shift_row);
      end
   endtask

   task automatic test_reset_mid_shift();
      go_write();
      sbus.row_full = 20'h00010;
      step(); step();
      reset = 1'b1;
      sbus.row_full = '0;
      step();
      reset = 1'b0;
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.lines !== 16'd0 || sbus.shift_row !== 5'd0 || sbus.shift_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_shift_reset: state=%b lines=%0d row=%0d se=%b, required 000/0/0/0",
                  sbus.state, sbus.lines, sbus.shift_row, sbus.shift_en);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b100) begin
         n_fail++;
         $display("FAIL mid_shift_add: state=%b, required 100", sbus.state);
      end
   endtask

   task automatic test_game_over();
      int bad;
      sbus.endgame_any = 1'b1;
      step();
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL go_spawnchk: state=%b go=%b, required 000/0", sbus.state, sbus.game_over);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL go_halt: state=%b go=%b, required 000/1", sbus.state, sbus.game_over);
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         sbus.row_full    = 20'($urandom);
         sbus.stop_any    = 1'($urandom);
         sbus.endgame_any = 1'($urandom);
         step();
         if (sbus.state !== 3'b000 || sbus.game_over !== 1'b1 || sbus.spawn !== 1'b0 || sbus.shift_en !== 1'b0)
            bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL go_sticky: %0d cycles left HALT, required 0", bad);
      end
      sbus.row_full = '0; sbus.stop_any = 0; sbus.endgame_any = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_tests++;
      if (sbus.state !== 3'b000 || sbus.game_over !== 1'b0 || sbus.lines !== 16'd0) begin
         n_fail++;
         $display("FAIL go_reset: state=%b go=%b lines=%0d, required 000/0/0", sbus.state, sbus.game_over, sbus.lines);
      end
      step();
      n_tests++;
      if (sbus.state !== 3'b100) begin
         n_fail++;
         $display("FAIL go_restart: state=%b, required 100", sbus.state);
      end
   endtask

`ifdef FALL_SEQ_SOFT_DROP_EN
   task automatic test_soft_drop();
      int n;
      sbus.drop = 1'b1;
      wait_fall();
      n = 0;
      do begin
         step();
         n++;
      end while (sbus.state !== ST_MOVE && n < 12);
      n_tests++;
      if (n !== 3) begin
         n_fail++;
         $display("FAIL soft_drop_period: period=%0d, required 3", n);
      end
      sbus.drop = 1'b0;
   endtask
`endif

   task automatic test_saturation();
      sbus2.row_full = 20'h00001;
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (12) step();
      n_tests++;
      if (sbus2.lines !== 3'd6 || sbus2.state !== 3'b000) begin
         n_fail++;
         $display("FAIL sat_mid: lines=%0d state=%b, required 6/000", sbus2.lines, sbus2.state);
      end
      repeat (8) step();
      n_tests++;
      if (sbus2.lines !== 3'd7) begin
         n_fail++;
         $display("FAIL sat_hold: lines=%0d, required 7", sbus2.lines);
      end
      step();
      n_tests++;
      if (sbus2.state !== 3'b011 || sbus2.lines !== 3'd7) begin
         n_fail++;
         $display("FAIL sat_shift: state=%b lines=%0d, required 011/7", sbus2.state, sbus2.lines);
      end
      step();
      n_tests++;
      if (sbus2.lines !== 3'd7) begin
         n_fail++;
         $display("FAIL sat_wrap: lines=%0d, required 7", sbus2.lines);
      end
      sbus2.row_full = '0;
   endtask

   initial begin
      test_reset();
      test_fall();
      test_double_clear();
      test_priority();
      test_reset_mid_shift();
      test_game_over();
`ifdef FALL_SEQ_SOFT_DROP_EN
      test_soft_drop();
`endif
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
